alu_seq: RTL

Parametrised, handshaked successor to the single-cycle 32-bit ALU. It keeps the existing logic, add/sub and compare operations at one-cycle registered latency, and adds iterative signed multiply, divide and remainder at fixed multi-cycle latency. It sits between the decode/issue stage and writeback in the multi-cycle datapath, and uses valid/ready handshakes on both its input and output sides.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bundle between issue, the sequential ALU and writeback.
//   Request side : in_valid/in_ready, A_in, B_in (signed operands), ALU_Sel.
//   Response side: out_valid/out_ready, ALU_Out and the flags Carry_Out,
//                  Overflow, Zero, Div_Zero (qualified by out_valid).
//   master = producer of operations / consumer of results, slave = the ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [3:0]       ALU_Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             Carry_Out;
    logic             Overflow;
    logic             Zero;
    logic             Div_Zero;

    modport master (
        output in_valid, A_in, B_in, ALU_Sel, out_ready,
        input  in_ready, out_valid, ALU_Out, Carry_Out, Overflow, Zero, Div_Zero
    );

    modport slave (
        input  in_valid, A_in, B_in, ALU_Sel, out_ready,
        output in_ready, out_valid, ALU_Out, Carry_Out, Overflow, Zero, Div_Zero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Logic/add/sub/compare finish one cycle after accept;
// signed MUL/MULH/DIV/REM run WIDTH shift-add / restoring-divide iterations on
// operand magnitudes, then a FIX cycle applies sign correction and special cases.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : alu_seq_if.slave (operation request in, registered result out)
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;      // low bits of an iterative select: 00 MUL, 01 MULH, 10 DIV, 11 REM
    logic [WIDTH-1:0]   r_a, r_b;  // original signed operands, kept for the FIX cycle
    logic [WIDTH-1:0]   r_m;       // |B|: multiplicand or divisor
    logic [WIDTH-1:0]   r_q;       // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0]   r_acc;     // product high / partial remainder
    logic [WIDTH-1:0]   r_out;
    logic               r_c, r_v, r_z, r_dz;

    // ---------------- single-cycle results, from the live inputs ----------------
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;
    logic             w_iter;
    logic [WIDTH-1:0] w_amag, w_bmag;

    assign w_iter = (bus.ALU_Sel[3:2] == 2'b10);
    // Magnitude of the minimum value wraps to 2^(WIDTH-1), which is correct unsigned.
    assign w_amag = bus.A_in[WIDTH-1] ? (~bus.A_in + 1'b1) : bus.A_in;
    assign w_bmag = bus.B_in[WIDTH-1] ? (~bus.B_in + 1'b1) : bus.B_in;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.ALU_Sel)
            4'b0000: w_res = bus.A_in & bus.B_in;
            4'b0001: w_res = bus.A_in | bus.B_in;
            4'b1100: w_res = ~(bus.A_in | bus.B_in);
            4'b0010: begin
                {w_c, w_res} = {1'b0, bus.A_in} + {1'b0, bus.B_in};
                w_v = (bus.A_in[WIDTH-1] == bus.B_in[WIDTH-1]) &&
                      (w_res[WIDTH-1] != bus.A_in[WIDTH-1]);
            end
            4'b0110: begin
                w_res = bus.A_in - bus.B_in;
                w_v = (bus.A_in[WIDTH-1] != bus.B_in[WIDTH-1]) &&
                      (w_res[WIDTH-1] != bus.A_in[WIDTH-1]);
            end
            4'b0111: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A_in) < $signed(bus.B_in))};
            4'b1111: w_res = {{(WIDTH-1){1'b0}}, (bus.A_in == bus.B_in)};
            default: w_res = '0;
        endcase
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0]   w_msum, w_dsh, w_dtry;
    logic             w_dbit;
    logic [WIDTH-1:0] w_drem;

    assign w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_dsh  = {r_acc, r_q[WIDTH-1]};
    assign w_dtry = w_dsh - {1'b0, r_m};
    assign w_dbit = ~w_dtry[WIDTH];                       // trial subtraction did not borrow
    assign w_drem = w_dbit ? w_dtry[WIDTH-1:0] : w_dsh[WIDTH-1:0];

    // ---------------- FIX: sign correction and special cases ----------------
    logic [2*WIDTH-1:0] w_prod, w_sprod;
    logic [WIDTH-1:0]   w_sq, w_sr, w_fout;
    logic               w_bz, w_dovf, w_fv, w_fdz;

    assign w_prod  = {r_acc, r_q};
    assign w_sprod = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_prod : w_prod;
    assign w_sq    = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_q : r_q;
    assign w_sr    = r_a[WIDTH-1] ? -r_acc : r_acc;
    assign w_bz    = (r_b == '0);
    assign w_dovf  = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);

    always_comb begin
        w_fout = '0;
        w_fv   = 1'b0;
        w_fdz  = 1'b0;
        case (r_op)
            2'b00: begin
                w_fout = w_sprod[WIDTH-1:0];
                w_fv   = (w_sprod[2*WIDTH-1:WIDTH] != {WIDTH{w_sprod[WIDTH-1]}});
            end
            2'b01: w_fout = w_sprod[2*WIDTH-1:WIDTH];
            2'b10: begin
                w_fout = w_bz ? '1 : w_sq;   // min/-1 quotient magnitude wraps back to min
                w_fv   = w_dovf;
                w_fdz  = w_bz;
            end
            default: begin
                w_fout = w_bz ? r_a : w_sr;
                w_fv   = w_dovf;
                w_fdz  = w_bz;
            end
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_next = w_iter ? S_CALC : S_DONE;
            S_CALC: if (r_cnt == CW'(WIDTH-1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0; r_op <= '0; r_a <= '0; r_b <= '0; r_m <= '0;
            r_q <= '0; r_acc <= '0; r_out <= '0;
            r_c <= 1'b0; r_v <= 1'b0; r_z <= 1'b0; r_dz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_op  <= bus.ALU_Sel[1:0];
                    r_a   <= bus.A_in;
                    r_b   <= bus.B_in;
                    r_m   <= w_bmag;
                    r_q   <= w_amag;
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (!w_iter) begin
                        r_out <= w_res;
                        r_c   <= w_c;
                        r_v   <= w_v;
                        r_z   <= (w_res == '0);
                        r_dz  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_op[1]) begin
                        {r_acc, r_q} <= {w_msum, r_q[WIDTH-1:1]};
                    end else begin
                        r_acc <= w_drem;
                        r_q   <= {r_q[WIDTH-2:0], w_dbit};
                    end
                end
                S_FIX: begin
                    r_out <= w_fout;
                    r_c   <= 1'b0;
                    r_v   <= w_fv;
                    r_z   <= (w_fout == '0);
                    r_dz  <= w_fdz;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.ALU_Out   = r_out;
    assign bus.Carry_Out = r_c;
    assign bus.Overflow  = r_v;
    assign bus.Zero      = r_z;
    assign bus.Div_Zero  = r_dz;
endmodule
